// File: rtl/ibex_wb_queue.sv
// In-order multi-entry writeback queue with RAW hazard detection for two ID read ports.
// Define IBEX_WB_QUEUE_FWD_EN to forward pending non-load results to ID instead of stalling.
module ibex_wb_queue #(
  parameter int unsigned Depth     = 4,
  parameter int unsigned DataWidth = 32
) (
  input  logic                         clk_i,
  input  logic                         rst_i,

  input  logic                         en_wb_i,
  input  logic [1:0]                   instr_type_wb_i,
  input  logic [DataWidth-1:0]         pc_id_i,
  input  logic                         instr_is_compressed_id_i,
  input  logic                         instr_perf_count_id_i,
  input  logic [4:0]                   rf_waddr_id_i,
  input  logic [DataWidth-1:0]         rf_wdata_id_i,
  input  logic                         rf_we_id_i,

  input  logic [DataWidth-1:0]         rf_wdata_lsu_i,
  input  logic                         rf_we_lsu_i,
  input  logic                         lsu_resp_valid_i,
  input  logic                         lsu_resp_err_i,

  input  logic [4:0]                   rf_raddr_a_i,
  input  logic [4:0]                   rf_raddr_b_i,

  output logic                         ready_wb_o,
  output logic                         hazard_a_o,
  output logic                         hazard_b_o,
  output logic                         fwd_valid_a_o,
  output logic                         fwd_valid_b_o,
  output logic [DataWidth-1:0]         fwd_data_a_o,
  output logic [DataWidth-1:0]         fwd_data_b_o,

  output logic [4:0]                   rf_waddr_wb_o,
  output logic [DataWidth-1:0]         rf_wdata_wb_o,
  output logic                         rf_we_wb_o,

  output logic                         outstanding_load_wb_o,
  output logic                         outstanding_store_wb_o,
  output logic [DataWidth-1:0]         pc_wb_o,
  output logic                         instr_done_wb_o,
  output logic                         perf_instr_ret_wb_o,
  output logic                         perf_instr_ret_compressed_wb_o,
  output logic [$clog2(Depth+1)-1:0]   occupancy_o,
  output logic                         resp_unexp_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = $clog2(Depth + 1);

  typedef enum logic [1:0] {
    WB_INSTR_OTHER = 2'd0,
    WB_INSTR_LOAD  = 2'd1,
    WB_INSTR_STORE = 2'd2
  } wb_instr_type_e;

  logic [Depth-1:0]     valid_q;
  logic [Depth-1:0]     we_q;
  logic [Depth-1:0]     compressed_q;
  logic [Depth-1:0]     perf_q;
  wb_instr_type_e       type_q  [Depth];
  logic [4:0]           waddr_q [Depth];
  logic [DataWidth-1:0] wdata_q [Depth];
  logic [DataWidth-1:0] pc_q    [Depth];

  logic [PtrW-1:0]      head_q, tail_q;
  logic [CntW-1:0]      count_q;
  logic                 resp_unexp_q;

  logic                 head_valid;
  wb_instr_type_e       head_type;
  logic                 head_done;
  logic                 head_rf_we;
  logic                 full;
  logic                 alloc;
  logic                 resp_unexp_set;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  assign head_valid = valid_q[head_q];
  assign head_type  = type_q[head_q];
  assign head_done  = head_valid & ((head_type == WB_INSTR_OTHER) | lsu_resp_valid_i);
  assign full       = (count_q == CntW'(Depth));
  assign ready_wb_o = ~full | head_done;
  assign alloc      = en_wb_i & ready_wb_o;

  // Only an empty queue or a non-LSU head can receive a stray response.
  assign resp_unexp_set = lsu_resp_valid_i & (~head_valid | (head_type == WB_INSTR_OTHER));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q      <= '0;
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      resp_unexp_q <= 1'b0;
    end else begin
      if (head_done) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= ptr_inc(head_q);
      end
      // Placed after the retire clear so a full queue recycling its head slot keeps it valid.
      if (alloc) begin
        valid_q[tail_q] <= 1'b1;
        tail_q          <= ptr_inc(tail_q);
      end
      count_q <= count_q + CntW'(alloc) - CntW'(head_done);
      if (resp_unexp_set) begin
        resp_unexp_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (alloc) begin
      type_q[tail_q]       <= wb_instr_type_e'(instr_type_wb_i);
      waddr_q[tail_q]      <= rf_waddr_id_i;
      wdata_q[tail_q]      <= rf_wdata_id_i;
      pc_q[tail_q]         <= pc_id_i;
      we_q[tail_q]         <= rf_we_id_i;
      compressed_q[tail_q] <= instr_is_compressed_id_i;
      perf_q[tail_q]       <= instr_perf_count_id_i;
    end
  end

  assign head_rf_we    = head_valid & we_q[head_q] & (head_type != WB_INSTR_LOAD);
  assign rf_we_wb_o    = head_rf_we | rf_we_lsu_i;
  assign rf_wdata_wb_o = head_rf_we ? wdata_q[head_q] : rf_wdata_lsu_i;
  assign rf_waddr_wb_o = head_valid ? waddr_q[head_q] : '0;
  assign pc_wb_o       = head_valid ? pc_q[head_q] : '0;

  assign instr_done_wb_o                = head_done;
  assign perf_instr_ret_wb_o            = head_done & perf_q[head_q] &
                                          ~(lsu_resp_valid_i & lsu_resp_err_i);
  assign perf_instr_ret_compressed_wb_o = perf_instr_ret_wb_o & compressed_q[head_q];
  assign occupancy_o                    = count_q;
  assign resp_unexp_o                   = resp_unexp_q;

  always_comb begin
    outstanding_load_wb_o  = 1'b0;
    outstanding_store_wb_o = 1'b0;
    for (int unsigned i = 0; i < Depth; i++) begin
      if (valid_q[i] && type_q[i] == WB_INSTR_LOAD)  outstanding_load_wb_o  = 1'b1;
      if (valid_q[i] && type_q[i] == WB_INSTR_STORE) outstanding_store_wb_o = 1'b1;
    end
  end

  logic                 match_a, match_b;
  logic [PtrW:0]        slot;
  logic [PtrW-1:0]      idx;
  logic                 writes_rf;
`ifdef IBEX_WB_QUEUE_FWD_EN
  logic                 load_a, load_b;
  logic [DataWidth-1:0] data_a, data_b;
`endif

  // Walk entries oldest to youngest so the last match seen is the youngest writer.
  always_comb begin
    match_a   = 1'b0;
    match_b   = 1'b0;
    slot      = '0;
    idx       = '0;
    writes_rf = 1'b0;
`ifdef IBEX_WB_QUEUE_FWD_EN
    load_a    = 1'b0;
    load_b    = 1'b0;
    data_a    = '0;
    data_b    = '0;
`endif
    for (int unsigned i = 0; i < Depth; i++) begin
      slot = {1'b0, head_q} + (PtrW+1)'(i);
      if (slot >= (PtrW+1)'(Depth)) slot = slot - (PtrW+1)'(Depth);
      idx       = slot[PtrW-1:0];
      writes_rf = valid_q[idx] & (we_q[idx] | (type_q[idx] == WB_INSTR_LOAD));
      if (writes_rf && rf_raddr_a_i != 5'd0 && waddr_q[idx] == rf_raddr_a_i) begin
        match_a = 1'b1;
`ifdef IBEX_WB_QUEUE_FWD_EN
        load_a  = (type_q[idx] == WB_INSTR_LOAD);
        data_a  = wdata_q[idx];
`endif
      end
      if (writes_rf && rf_raddr_b_i != 5'd0 && waddr_q[idx] == rf_raddr_b_i) begin
        match_b = 1'b1;
`ifdef IBEX_WB_QUEUE_FWD_EN
        load_b  = (type_q[idx] == WB_INSTR_LOAD);
        data_b  = wdata_q[idx];
`endif
      end
    end
  end

`ifdef IBEX_WB_QUEUE_FWD_EN
  assign hazard_a_o    = match_a & load_a;
  assign hazard_b_o    = match_b & load_b;
  assign fwd_valid_a_o = match_a & ~load_a;
  assign fwd_valid_b_o = match_b & ~load_b;
  assign fwd_data_a_o  = (match_a & ~load_a) ? data_a : '0;
  assign fwd_data_b_o  = (match_b & ~load_b) ? data_b : '0;
`else
  assign hazard_a_o    = match_a;
  assign hazard_b_o    = match_b;
  assign fwd_valid_a_o = 1'b0;
  assign fwd_valid_b_o = 1'b0;
  assign fwd_data_a_o  = '0;
  assign fwd_data_b_o  = '0;
`endif

  a_no_alloc_when_full: assert property (@(posedge clk_i) disable iff (rst_i)
    !(alloc && full && !head_done));
  a_lsu_we_needs_load_head: assert property (@(posedge clk_i) disable iff (rst_i)
    rf_we_lsu_i |-> (head_valid && head_type == WB_INSTR_LOAD));
  a_single_rf_write_source: assert property (@(posedge clk_i) disable iff (rst_i)
    !(head_rf_we && rf_we_lsu_i));

endmodule

// File: tb/tb_ibex_wb_queue.sv
// Scoreboarded bench for ibex_wb_queue: expected RF writes queued at allocation, checked at retirement.
module tb_ibex_wb_queue;
  localparam int unsigned Depth = 4;
  localparam int unsigned DW    = 32;
  localparam logic [1:0] T_OTHER = 2'd0, T_LOAD = 2'd1, T_STORE = 2'd2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          en, cmp, perf, we, lsu_we, resp_v, resp_err;
  logic [1:0]    ty;
  logic [DW-1:0] pc, wdata, lsu_data;
  logic [4:0]    waddr, raddr_a, raddr_b;

  logic          ready, haz_a, haz_b, fv_a, fv_b, rf_we_wb;
  logic [DW-1:0] fd_a, fd_b, rf_wdata_wb, pc_wb;
  logic [4:0]    rf_waddr_wb;
  logic          out_ld, out_st, done, pret, pret_c, unexp;
  logic [2:0]    occ;

  ibex_wb_queue #(.Depth(Depth), .DataWidth(DW)) dut (
    .clk_i(clk), .rst_i(rst),
    .en_wb_i(en), .instr_type_wb_i(ty), .pc_id_i(pc),
    .instr_is_compressed_id_i(cmp), .instr_perf_count_id_i(perf),
    .rf_waddr_id_i(waddr), .rf_wdata_id_i(wdata), .rf_we_id_i(we),
    .rf_wdata_lsu_i(lsu_data), .rf_we_lsu_i(lsu_we),
    .lsu_resp_valid_i(resp_v), .lsu_resp_err_i(resp_err),
    .rf_raddr_a_i(raddr_a), .rf_raddr_b_i(raddr_b),
    .ready_wb_o(ready), .hazard_a_o(haz_a), .hazard_b_o(haz_b),
    .fwd_valid_a_o(fv_a), .fwd_valid_b_o(fv_b),
    .fwd_data_a_o(fd_a), .fwd_data_b_o(fd_b),
    .rf_waddr_wb_o(rf_waddr_wb), .rf_wdata_wb_o(rf_wdata_wb), .rf_we_wb_o(rf_we_wb),
    .outstanding_load_wb_o(out_ld), .outstanding_store_wb_o(out_st),
    .pc_wb_o(pc_wb), .instr_done_wb_o(done),
    .perf_instr_ret_wb_o(pret), .perf_instr_ret_compressed_wb_o(pret_c),
    .occupancy_o(occ), .resp_unexp_o(unexp)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [4:0]    addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t           sb[$];
  logic [DW-1:0] ld_q[$];
  wr_t           mon_e;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && rf_we_wb) begin
      if (sb.size() == 0) begin
        chk("wb_unexpected_write", 64'(rf_we_wb), 64'(0));
      end else begin
        mon_e = sb.pop_front();
        chk("wb_addr", 64'(rf_waddr_wb), 64'(mon_e.addr));
        chk("wb_data", 64'(rf_wdata_wb), 64'(mon_e.data));
      end
    end
  end

  task automatic clr();
    en = 1'b0; ty = T_OTHER; pc = '0; cmp = 1'b0; perf = 1'b0;
    waddr = '0; wdata = '0; we = 1'b0;
    lsu_data = '0; lsu_we = 1'b0; resp_v = 1'b0; resp_err = 1'b0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    clr();
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic rst_pulse();
    rst = 1'b1;
    clr();
    sb.delete();
    ld_q.delete();
    cyc();
    rst = 1'b0;
  endtask

  // For loads, d is the data the bench will later return on the LSU response.
  task automatic alloc(input logic [1:0] t, input logic [4:0] a, input logic [DW-1:0] d,
                       input logic w);
    en = 1'b1; ty = t; waddr = a; we = (t == T_OTHER) ? w : 1'b0;
    wdata = (t == T_LOAD) ? ~d : d;
    perf = 1'b1;
    if (t == T_OTHER && w) sb.push_back('{addr: a, data: d});
    if (t == T_LOAD) begin
      ld_q.push_back(d);
      if (w) sb.push_back('{addr: a, data: d});
    end
  endtask

  task automatic resp(input logic err_v, input logic wr);
    resp_v = 1'b1; resp_err = err_v; lsu_we = wr;
    if (ld_q.size() > 0) lsu_data = ld_q.pop_front();
  endtask

  initial begin
    raddr_a = '0; raddr_b = '0;
    rst = 1'b1; clr();
    cyc();
    rst_pulse();

    // Reset state
    smp();
    chk("rst_ready", 64'(ready), 64'(1));
    chk("rst_occ", 64'(occ), 64'(0));
    chk("rst_we", 64'(rf_we_wb), 64'(0));
    chk("rst_pc", 64'(pc_wb), 64'(0));
    chk("rst_unexp", 64'(unexp), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    cyc();

    // Back-to-back OTHER writes x1..x4
    for (int i = 1; i <= 4; i++) begin
      alloc(T_OTHER, 5'(i), 32'(32'h11 * i), 1'b1);
      pc = 32'(32'h100 + 4 * i);
      smp();
      chk("t1_ready", 64'(ready), 64'(1));
      chk("t1_occ", 64'(occ), 64'((i == 1) ? 0 : 1));
      chk("t1_done", 64'(done), 64'((i == 1) ? 0 : 1));
      chk("t1_pc", 64'(pc_wb), 64'((i == 1) ? 0 : 32'h100 + 4 * (i - 1)));
      cyc();
    end
    smp();
    chk("t1_tail_occ", 64'(occ), 64'(1));
    chk("t1_tail_pc", 64'(pc_wb), 64'(32'h110));
    chk("t1_tail_perf", 64'(pret), 64'(1));
    cyc();
    smp();
    chk("t1_empty_occ", 64'(occ), 64'(0));
    chk("t1_empty_we", 64'(rf_we_wb), 64'(0));
    cyc();

    // Fill with loads, then respond while allocating
    for (int i = 0; i < 4; i++) begin
      alloc(T_LOAD, 5'(6 + i), 32'hDA7A_0006 + 32'(i), 1'b1);
      smp();
      chk("t2_fill_ready", 64'(ready), 64'(1));
      cyc();
    end
    smp();
    chk("t2_full_occ", 64'(occ), 64'(4));
    chk("t2_full_ready", 64'(ready), 64'(0));
    chk("t2_out_ld", 64'(out_ld), 64'(1));
    chk("t2_full_done", 64'(done), 64'(0));
    cyc();
    for (int i = 0; i < 4; i++) begin
      smp();
      chk("t2_stall_ready", 64'(ready), 64'(0));
      cyc();
    end
    resp(1'b0, 1'b1);
    alloc(T_OTHER, 5'd10, 32'h55, 1'b1);
    smp();
    chk("t2_resp_ready", 64'(ready), 64'(1));
    chk("t2_resp_done", 64'(done), 64'(1));
    chk("t2_resp_we", 64'(rf_we_wb), 64'(1));
    chk("t2_resp_data", 64'(rf_wdata_wb), 64'(32'hDA7A_0006));
    cyc();
    smp();
    chk("t2_occ_kept", 64'(occ), 64'(4));
    cyc();
    for (int i = 0; i < 3; i++) begin
      resp(1'b0, 1'b1);
      smp();
      chk("t2_drain_done", 64'(done), 64'(1));
      cyc();
    end
    smp();
    chk("t2_other_done", 64'(done), 64'(1));
    cyc();
    smp();
    chk("t2_drained", 64'(occ), 64'(0));
    cyc();

    // Forwarding / hazards on x5 behind a blocking load
    alloc(T_LOAD, 5'd20, 32'hDA7A_0020, 1'b1);
    smp(); cyc();
    alloc(T_OTHER, 5'd5, 32'hA, 1'b1);
    smp(); cyc();
    raddr_a = 5'd5; raddr_b = 5'd5;
    smp();
`ifdef IBEX_WB_QUEUE_FWD_EN
    chk("t3_fwd_a_v", 64'(fv_a), 64'(1));
    chk("t3_fwd_a_d", 64'(fd_a), 64'(32'hA));
    chk("t3_fwd_a_haz", 64'(haz_a), 64'(0));
`else
    chk("t3_nofwd_a_haz", 64'(haz_a), 64'(1));
    chk("t3_nofwd_a_v", 64'(fv_a), 64'(0));
`endif
    cyc();
    alloc(T_OTHER, 5'd5, 32'hB, 1'b1);
    smp(); cyc();
    smp();
`ifdef IBEX_WB_QUEUE_FWD_EN
    chk("t3_young_a_d", 64'(fd_a), 64'(32'hB));
    chk("t3_young_b_d", 64'(fd_b), 64'(32'hB));
    chk("t3_young_b_v", 64'(fv_b), 64'(1));
`else
    chk("t3_nofwd_b_haz", 64'(haz_b), 64'(1));
    chk("t3_nofwd_b_d", 64'(fd_b), 64'(0));
`endif
    cyc();
    alloc(T_LOAD, 5'd5, 32'hDA7A_0005, 1'b1);
    smp(); cyc();
    smp();
    chk("t3_ld_haz_a", 64'(haz_a), 64'(1));
    chk("t3_ld_fv_a", 64'(fv_a), 64'(0));
    chk("t3_ld_haz_b", 64'(haz_b), 64'(1));
    raddr_a = 5'd0; raddr_b = 5'd7;
    #1;
    chk("t3_x0_haz", 64'(haz_a), 64'(0));
    chk("t3_x0_fv", 64'(fv_a), 64'(0));
    chk("t3_nomatch_haz", 64'(haz_b), 64'(0));
    chk("t3_nomatch_fv", 64'(fv_b), 64'(0));
    cyc();
    raddr_a = '0; raddr_b = '0;
    resp(1'b0, 1'b1);
    smp(); cyc();
    smp(); cyc();
    smp(); cyc();
    resp(1'b0, 1'b1);
    smp();
    chk("t3_last_done", 64'(done), 64'(1));
    cyc();
    smp();
    chk("t3_drained", 64'(occ), 64'(0));
    cyc();

    // Load error suppresses perf; good compressed load counts; store
    alloc(T_LOAD, 5'd11, 32'hBAD, 1'b0);
    smp(); cyc();
    resp(1'b1, 1'b0);
    smp();
    chk("t4_err_done", 64'(done), 64'(1));
    chk("t4_err_perf", 64'(pret), 64'(0));
    chk("t4_err_we", 64'(rf_we_wb), 64'(0));
    cyc();
    alloc(T_LOAD, 5'd12, 32'hC0DE, 1'b1);
    cmp = 1'b1;
    smp(); cyc();
    resp(1'b0, 1'b1);
    smp();
    chk("t4_ok_perf", 64'(pret), 64'(1));
    chk("t4_ok_perf_c", 64'(pret_c), 64'(1));
    cyc();
    alloc(T_STORE, 5'd13, 32'h0, 1'b0);
    smp(); cyc();
    smp();
    chk("t4_out_st", 64'(out_st), 64'(1));
    chk("t4_st_wait", 64'(done), 64'(0));
    resp(1'b0, 1'b0);
    #1;
    chk("t4_st_done", 64'(done), 64'(1));
    cyc();
    smp();
    chk("t4_drained", 64'(occ), 64'(0));
    chk("t4_no_unexp", 64'(unexp), 64'(0));
    cyc();

    // Unexpected responses
    resp(1'b0, 1'b0);
    smp();
    chk("t5_unexp_pre", 64'(unexp), 64'(0));
    cyc();
    smp();
    chk("t5_unexp_set", 64'(unexp), 64'(1));
    cyc(); cyc(); cyc();
    smp();
    chk("t5_unexp_sticky", 64'(unexp), 64'(1));
    rst_pulse();
    smp();
    chk("t5_unexp_clr", 64'(unexp), 64'(0));
    cyc();
    alloc(T_OTHER, 5'd12, 32'h77, 1'b1);
    smp(); cyc();
    resp(1'b0, 1'b0);
    smp();
    chk("t5_other_done", 64'(done), 64'(1));
    cyc();
    smp();
    chk("t5_other_unexp", 64'(unexp), 64'(1));
    chk("t5_other_occ", 64'(occ), 64'(0));
    cyc();

    // Reset with pending entries
    rst_pulse();
    for (int i = 0; i < 3; i++) begin
      alloc(T_LOAD, 5'(14 + i), 32'hF00 + 32'(i), 1'b1);
      smp(); cyc();
    end
    smp();
    chk("t6_pending_occ", 64'(occ), 64'(3));
    rst_pulse();
    smp();
    chk("t6_occ", 64'(occ), 64'(0));
    chk("t6_we", 64'(rf_we_wb), 64'(0));
    chk("t6_pc", 64'(pc_wb), 64'(0));
    chk("t6_out_ld", 64'(out_ld), 64'(0));
    chk("t6_ready", 64'(ready), 64'(1));
    cyc();
    cyc();

    chk("sb_drained", 64'(sb.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ibex_wb_queue.md
Name: ibex_wb_queue

Overview:
Multi-entry, in-order writeback queue. It replaces the single-slot writeback stage so that several load/store or ALU results can be in flight between ID/EX and the register file. Entries are allocated from ID/EX and retired one per cycle from the head: non-LSU entries retire immediately, LSU entries retire on an LSU response. The block also provides RAW hazard detection and youngest-match forwarding to ID for two read ports.

Parameters:
Depth, 4, number of queue entries; legal range 2..16, any integer (not restricted to powers of two).
DataWidth, 32, width of register write data and of the PC.

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
en_wb_i  in  1  allocate request from ID/EX; honoured only when ready_wb_o=1
instr_type_wb_i  in  2  wb_instr_type_e: OTHER, LOAD, STORE
pc_id_i  in  DataWidth  instruction PC
instr_is_compressed_id_i  in  1  compressed flag
instr_perf_count_id_i  in  1  counts toward instret
rf_waddr_id_i  in  5  destination register
rf_wdata_id_i  in  DataWidth  ALU result
rf_we_id_i  in  1  non-load RF write enable
rf_wdata_lsu_i  in  DataWidth  load data
rf_we_lsu_i  in  1  load RF write enable
lsu_resp_valid_i  in  1  LSU response, in order
lsu_resp_err_i  in  1  LSU response error
rf_raddr_a_i, rf_raddr_b_i  in  5 each  ID read addresses
ready_wb_o  out  1  entry can be allocated this cycle
hazard_a_o, hazard_b_o  out  1 each  matching write is pending and cannot be forwarded
fwd_valid_a_o, fwd_valid_b_o  out  1 each  forward data is valid
fwd_data_a_o, fwd_data_b_o  out  DataWidth each  forwarded data
rf_waddr_wb_o  out  5  RF write address
rf_wdata_wb_o  out  DataWidth  RF write data
rf_we_wb_o  out  1  RF write enable
outstanding_load_wb_o  out  1  any valid LOAD entry
outstanding_store_wb_o  out  1  any valid STORE entry
pc_wb_o  out  DataWidth  head PC; 0 when empty
instr_done_wb_o  out  1  head retires this cycle
perf_instr_ret_wb_o  out  1  retired instruction counted
perf_instr_ret_compressed_wb_o  out  1  retired compressed instruction counted
occupancy_o  out  $clog2(Depth+1)  number of valid entries
resp_unexp_o  out  1  sticky: LSU response with no LSU head

Behaviour:
- Storage is a circular buffer with head/tail pointers. Pointers wrap from Depth-1 to 0. There is an explicit count; full is count==Depth.
- Reset (rst_i at a clock edge):
  - All entries are invalidated; pointers and count go to 0; resp_unexp_o goes to 0.
  - All outputs are then 0, except ready_wb_o, which is 1.
  - A reset mid-operation discards in-flight entries with no RF write.
- head_done = head valid & (type==OTHER | lsu_resp_valid_i).
- instr_done_wb_o = head_done. On head_done, head advances and count decrements.
- Allocation: alloc = en_wb_i & ready_wb_o. The new entry is written at tail on the next edge.
- ready_wb_o = ~full | head_done. The slot freed by retirement is reusable in the same cycle.
- Simultaneous alloc and retire: count is unchanged; both pointers advance.
- Empty queue with en_wb_i: the entry is visible at head on the next cycle. There is no same-cycle passthrough; minimum latency is 1 cycle.
- RF write port:
  - rf_waddr_wb_o is the head waddr.
  - rf_we_wb_o = (head valid & head rf_we & type≠LOAD) | rf_we_lsu_i.
  - rf_wdata_wb_o takes the head wdata when the head-entry term is set, otherwise rf_wdata_lsu_i.
- Perf outputs:
  - perf_instr_ret_wb_o = head_done & head count & ~(lsu_resp_valid_i & lsu_resp_err_i).
  - perf_instr_ret_compressed_wb_o = perf_instr_ret_wb_o & head compressed.
- Hazard and forwarding, per read port, combinational:
  - Match = valid entry with (rf_we | type==LOAD) and waddr == raddr, where raddr≠0.
  - The youngest match wins.
  - If the youngest match is a non-load with rf_we: fwd_valid=1, fwd_data = entry wdata, hazard=0.
  - If the youngest match is a LOAD: hazard=1, fwd_valid=0.
  - No match: all three outputs are 0.
- LSU contract:
  - An LSU response belongs to the head entry only.
  - lsu_resp_valid_i while the queue is empty, or while the head is OTHER, sets resp_unexp_o. The response is dropped and the head (if OTHER) retires normally.
  - resp_unexp_o is cleared only by rst_i.
- SVA checks:
  - No alloc when full & ~head_done.
  - rf_we_lsu_i implies head is LOAD.
  - Two RF write sources are never asserted together.

Optional Feature:
IBEX_WB_QUEUE_FWD_EN:
- Defined: forwarding operates as described in Behaviour.
- Undefined: fwd_valid_*_o and fwd_data_*_o are tied to 0, and every match, load or not, raises hazard_*_o. ID stalls until the match retires.

Test Plan:
1. Reset, then Depth=4 back-to-back OTHER allocs with rf_we to x1..x4, data 0x11..0x44 -> writes appear on cycles 1..4; occupancy never exceeds 1; ready_wb_o stays 1.
2. Four LOADs with no response -> occupancy=4, ready_wb_o=0. Response on cycle 10 with en_wb_i=1 -> ready_wb_o=1 in the same cycle; occupancy stays 4; the LOAD's RF write carries rf_wdata_lsu_i.
3. Enqueue OTHER x5=0xA, then OTHER x5=0xB; set raddr_a=5 -> fwd_data_a_o=0xB, fwd_valid_a_o=1. Then enqueue LOAD x5 -> hazard_a_o=1, fwd_valid_a_o=0. raddr=0 -> no hazard.
4. LOAD head, response with lsu_resp_err_i=1 and count=1 -> instr_done_wb_o=1, perf_instr_ret_wb_o=0.
5. lsu_resp_valid_i on an empty queue -> resp_unexp_o=1 and stays 1 until rst_i.
6. rst_i with 3 entries pending -> next cycle occupancy=0, rf_we_wb_o=0, pc_wb_o=0. Repeat scenario 3 with the macro undefined -> hazard_a_o=1 for the OTHER matches.
